// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite encodings for the two-master arbiter
// Contents: HTRANS and HRESP encodings, port FSM state encoding, address-phase record.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    PS_IDLE = 2'b00,
    PS_PEND = 2'b01,
    PS_DATA = 2'b10
  } port_state_e;

  // One address phase as offered to the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic        write;
  } addr_phase_t;

endpackage

// File: rtl/ahbl_arbiter_2_if.sv
// rtl/ahbl_arbiter_2_if.sv - one AHB-Lite link between a master and a slave
// master modport: drives haddr/htrans/hsize/hwrite/hwdata, receives hready/hrdata/hresp.
// slave modport : the mirror image.
interface ahbl_arbiter_2_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  modport master (output haddr, htrans, hsize, hwrite, hwdata,
                  input  hready, hrdata, hresp);
  modport slave  (input  haddr, htrans, hsize, hwrite, hwdata,
                  output hready, hrdata, hresp);
endinterface

// File: rtl/ahbl_arb_port.sv
// rtl/ahbl_arb_port.sv - per-master port: one-entry address buffer, IDLE/PEND/DATA FSM
// Ports: HCLK, HRESETn     clock, async active-low reset
//        m                 master link (slave side): requests in, hready/hresp/hrdata out
//        bus_hready/hresp/hrdata  shared bus return signals
//        grant             arbiter selected this port in this cycle
//        dsel              this port owns the current bus data phase
//        cand              port is competing for the bus (buffered or live request)
//        pend              port holds a buffered request
//        src               address phase the port offers (buffer when pending, else live inputs)
module ahbl_arb_port
  import ahbl_pkg::*;
(
  input  logic            HCLK,
  input  logic            HRESETn,
  ahbl_arbiter_2_if.slave m,
  input  logic            bus_hready,
  input  logic            bus_hresp,
  input  logic [31:0]     bus_hrdata,
  input  logic            grant,
  input  logic            dsel,
  output logic            cand,
  output logic            pend,
  output addr_phase_t     src
);

  port_state_e state;
  addr_phase_t buffer;
  addr_phase_t live_ap;
  logic        live;
  logic        take;

  assign live_ap = {m.haddr, m.htrans, m.hsize, m.hwrite};
  assign pend    = (state == PS_PEND);

  // While in DATA the master's data phase is the bus data phase, so bus wait states pass through.
  assign m.hready = (state == PS_IDLE) || ((state == PS_DATA) && bus_hready);
  assign m.hresp  = dsel ? bus_hresp : HRESP_OKAY;
  assign m.hrdata = bus_hrdata;

  assign live = m.htrans[1] && m.hready;
  assign cand = live || pend;
  assign take = grant && bus_hready;
  assign src  = pend ? buffer : live_ap;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= PS_IDLE;
      buffer <= '0;
    end else begin
      case (state)
        PS_PEND: if (take) state <= PS_DATA;
        default: begin
          if (live) begin
            if (take) begin
              state <= PS_DATA;
            end else begin
              // The master already saw HREADY=1, so the request must be kept here.
              state  <= PS_PEND;
              buffer <= live_ap;
            end
          end else if ((state == PS_DATA) && bus_hready) begin
            state <= PS_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ahbl_arbiter_2.sv
// rtl/ahbl_arbiter_2.sv - two-master AHB-Lite arbiter sharing one bus between M0 (CPU) and M1 (DMA)
// Params: RR       1 = round-robin on ties, 0 = fixed priority (M0 wins)
// Ports:  HCLK, HRESETn   clock, async active-low reset
//         m0, m1          master links (slave side)
//         bus             shared bus (master side) towards the splitter
//         HMASTER         current address-phase owner
module ahbl_arbiter_2
  import ahbl_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahbl_arbiter_2_if.slave  m0,
  ahbl_arbiter_2_if.slave  m1,
  ahbl_arbiter_2_if.master bus,
  output logic             HMASTER
);

  logic [1:0]  cand;
  logic [1:0]  pend;
  logic [1:0]  grant;
  logic [1:0]  dsel;
  logic [1:0]  pool;
  addr_phase_t src [2];
  addr_phase_t sel_ap;
  logic        gnt_any;
  logic        gnt_sel;
  logic        tie_sel;
  logic        rr_ptr;
  logic        owner;
  logic        dvalid;
  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;

  ahbl_arb_port u_port0 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .m          (m0),
    .bus_hready (bus.hready),
    .bus_hresp  (bus.hresp),
    .bus_hrdata (bus.hrdata),
    .grant      (grant[0]),
    .dsel       (dsel[0]),
    .cand       (cand[0]),
    .pend       (pend[0]),
    .src        (src[0])
  );

  ahbl_arb_port u_port1 (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .m          (m1),
    .bus_hready (bus.hready),
    .bus_hresp  (bus.hresp),
    .bus_hrdata (bus.hrdata),
    .grant      (grant[1]),
    .dsel       (dsel[1]),
    .cand       (cand[1]),
    .pend       (pend[1]),
    .src        (src[1])
  );

  assign tie_sel = RR ? rr_ptr : 1'b0;
  // Buffered requests have already been held off once, so they beat fresh requests;
  // otherwise a fixed-priority M0 could starve a buffered M1 forever.
  assign pool    = (pend != 2'b00) ? pend : cand;
  // No grant while HREADY=0: the address phase on the bus cannot change until it completes.
  assign gnt_any = HRESETn && bus.hready && (pool != 2'b00);
  assign gnt_sel = (pool == 2'b11) ? tie_sel : pool[1];
  assign grant   = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign dsel    = dvalid ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign sel_ap  = src[gnt_sel];

  always_comb begin
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = haddr_q;
    bus.hsize  = hsize_q;
    bus.hwrite = hwrite_q;
    if (gnt_any) begin
      bus.haddr  = sel_ap.addr;
      bus.hsize  = sel_ap.size;
      bus.hwrite = sel_ap.write;
      // A delayed transfer or a new owner cannot continue a burst the slave was tracking.
      bus.htrans = (pend[gnt_sel] || (gnt_sel != owner)) ? HTRANS_NONSEQ : sel_ap.trans;
    end
  end

  assign bus.hwdata = owner ? m1.hwdata : m0.hwdata;
  assign HMASTER    = gnt_any ? gnt_sel : owner;

  // owner doubles as the data-phase owner: it is updated exactly when a transfer is accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      dvalid   <= 1'b0;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
    end else begin
      haddr_q  <= bus.haddr;
      hsize_q  <= bus.hsize;
      hwrite_q <= bus.hwrite;
      if (bus.hready) begin
        dvalid <= gnt_any;
        if (gnt_any) begin
          owner  <= gnt_sel;
          rr_ptr <= ~gnt_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter_2.sv
// tb/tb_ahbl_arbiter_2.sv - self-checking bench for ahbl_arbiter_2 (directed steps then random cycles)
module tb_ahbl_arbiter_2;
  import ahbl_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic HMASTER;

  ahbl_arbiter_2_if m0();
  ahbl_arbiter_2_if m1();
  ahbl_arbiter_2_if bus();

  ahbl_arbiter_2 #(.RR(1'b1)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .m0      (m0),
    .m1      (m1),
    .bus     (bus),
    .HMASTER (HMASTER)
  );

  always #5 HCLK = ~HCLK;

  // stimulus
  addr_phase_t inp [2];
  logic [31:0] wd [2];
  logic        hr;
  logic        resp_in;
  logic [31:0] rd_in;

  // reference model: each master either waits with a held request, sits in a data phase, or neither
  bit          waiting [2];
  bit          in_data [2];
  addr_phase_t held [2];
  bit          owner_m;
  bit          dvalid_m;
  bit          favour;
  logic [31:0] last_addr;
  logic [2:0]  last_size;
  logic        last_write;

  // decision of the current cycle
  bit          fresh [2];
  bit          win;
  bit          w;
  logic [31:0] e_addr;
  logic [2:0]  e_size;
  logic        e_write;
  logic [1:0]  e_trans;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    m0.haddr = inp[0].addr; m0.htrans = inp[0].trans; m0.hsize = inp[0].size;
    m0.hwrite = inp[0].write; m0.hwdata = wd[0];
    m1.haddr = inp[1].addr; m1.htrans = inp[1].trans; m1.hsize = inp[1].size;
    m1.hwrite = inp[1].write; m1.hwdata = wd[1];
    bus.hready = hr; bus.hresp = resp_in; bus.hrdata = rd_in;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      waiting[i] = 1'b0; in_data[i] = 1'b0; held[i] = '0;
    end
    owner_m = 1'b0; dvalid_m = 1'b0; favour = 1'b0;
    last_addr = '0; last_size = '0; last_write = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [1:0] t, input logic wr);
    inp[i].addr = a; inp[i].trans = t; inp[i].size = 3'd2; inp[i].write = wr;
  endtask

  // Drive this cycle's inputs, predict and compare every output before the edge.
  task automatic eval(input string tag);
    bit rdy [2];
    bit pool [2];
    bit anyw;
    addr_phase_t s;
    drive();
    #2;
    anyw = waiting[0] || waiting[1];
    for (int i = 0; i < 2; i++) begin
      rdy[i]   = waiting[i] ? 1'b0 : (in_data[i] ? hr : 1'b1);
      fresh[i] = rdy[i] && inp[i].trans[1];
      pool[i]  = anyw ? waiting[i] : fresh[i];
    end
    win = hr && (pool[0] || pool[1]);
    if (pool[0] && pool[1]) w = favour;
    else if (pool[0])       w = 1'b0;
    else                    w = 1'b1;
    s = waiting[w] ? held[w] : inp[w];
    if (win) begin
      e_addr = s.addr; e_size = s.size; e_write = s.write;
      e_trans = (waiting[w] || (w != owner_m)) ? 2'b10 : s.trans;
    end else begin
      e_addr = last_addr; e_size = last_size; e_write = last_write; e_trans = 2'b00;
    end
    chk({tag, ".m0_hready"}, m0.hready, rdy[0]);
    chk({tag, ".m1_hready"}, m1.hready, rdy[1]);
    chk({tag, ".htrans"}, bus.htrans, e_trans);
    chk({tag, ".haddr"}, bus.haddr, e_addr);
    chk({tag, ".hsize_hwrite"}, {bus.hsize, bus.hwrite}, {e_size, e_write});
    chk({tag, ".hmaster"}, HMASTER, win ? w : owner_m);
    chk({tag, ".hwdata"}, bus.hwdata, owner_m ? wd[1] : wd[0]);
    chk({tag, ".m0_hresp"}, m0.hresp, (dvalid_m && !owner_m) ? resp_in : 1'b0);
    chk({tag, ".m1_hresp"}, m1.hresp, (dvalid_m && owner_m) ? resp_in : 1'b0);
    chk({tag, ".m1_hrdata"}, m1.hrdata, rd_in);
  endtask

  task automatic adv();
    @(posedge HCLK);
    for (int i = 0; i < 2; i++) begin
      bit g;
      g = win && (int'(w) == i);
      if (!g && fresh[i]) held[i] = inp[i];
      waiting[i] = !g && (waiting[i] || fresh[i]);
      in_data[i] = g || (in_data[i] && !hr);
    end
    if (hr) begin
      dvalid_m = win;
      if (win) begin
        owner_m = w;
        favour  = !w;
      end
    end
    last_addr = e_addr; last_size = e_size; last_write = e_write;
    #1;
  endtask

  task automatic idle_masters();
    set_req(0, 32'h0, 2'b00, 1'b0);
    set_req(1, 32'h0, 2'b00, 1'b0);
  endtask

  initial begin
    idle_masters();
    wd[0] = 32'h1111_1111; wd[1] = 32'h0; hr = 1'b1; resp_in = 1'b1; rd_in = 32'h0;
    drive();
    model_reset();
    #12;
    chk("rst.m0_hready", m0.hready, 1'b1);
    chk("rst.m1_hready", m1.hready, 1'b1);
    chk("rst.m0_hresp", m0.hresp, 1'b0);
    chk("rst.m1_hresp", m1.hresp, 1'b0);
    chk("rst.htrans", bus.htrans, 2'b00);
    chk("rst.haddr", bus.haddr, 32'h0);
    chk("rst.hmaster", HMASTER, 1'b0);
    resp_in = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // collision with round-robin: M0 first, M1 buffered, then M1 ahead of M0's next request
    set_req(0, 32'h0000_0100, 2'b10, 1'b0);
    set_req(1, 32'h0000_0200, 2'b10, 1'b0);
    eval("col1");
    chk("col1.haddr_m0", bus.haddr, 32'h0000_0100);
    adv();
    set_req(0, 32'h0000_0104, 2'b11, 1'b0);
    eval("col2");
    chk("col2.m1_buffered", m1.hready, 1'b0);
    chk("col2.haddr_m1", bus.haddr, 32'h0000_0200);
    chk("col2.nonseq", bus.htrans, 2'b10);
    chk("col2.hmaster_m1", HMASTER, 1'b1);
    adv();
    idle_masters();
    eval("col3");
    chk("col3.haddr_m0", bus.haddr, 32'h0000_0104);
    chk("col3.forced_nonseq", bus.htrans, 2'b10);
    adv();
    eval("col4"); adv();

    // single master read
    set_req(0, 32'h0000_0010, 2'b10, 1'b0);
    eval("rd1");
    chk("rd1.htrans", bus.htrans, 2'b10);
    chk("rd1.haddr", bus.haddr, 32'h0000_0010);
    chk("rd1.m1_hready", m1.hready, 1'b1);
    adv();
    idle_masters(); rd_in = 32'hDEAD_BEEF;
    eval("rd2");
    chk("rd2.hrdata", m0.hrdata, 32'hDEAD_BEEF);
    chk("rd2.m0_hready", m0.hready, 1'b1);
    adv();

    // wait states in M1's data phase, M0 buffered meanwhile
    set_req(1, 32'h0000_0300, 2'b10, 1'b0);
    eval("ws1");
    chk("ws1.hmaster", HMASTER, 1'b1);
    adv();
    hr = 1'b0; idle_masters(); set_req(0, 32'h0000_0400, 2'b10, 1'b0);
    eval("ws2");
    chk("ws2.m1_hready", m1.hready, 1'b0);
    chk("ws2.htrans", bus.htrans, 2'b00);
    adv();
    idle_masters();
    for (int k = 0; k < 2; k++) begin
      eval("ws3");
      chk("ws3.m1_hready", m1.hready, 1'b0);
      chk("ws3.m0_hready", m0.hready, 1'b0);
      chk("ws3.hmaster_frozen", HMASTER, 1'b1);
      adv();
    end
    hr = 1'b1;
    eval("ws4");
    chk("ws4.haddr_m0", bus.haddr, 32'h0000_0400);
    chk("ws4.htrans", bus.htrans, 2'b10);
    chk("ws4.m1_hready", m1.hready, 1'b1);
    adv();

    // write steering
    set_req(1, 32'h2000_0000, 2'b10, 1'b1);
    eval("wr1");
    chk("wr1.haddr", bus.haddr, 32'h2000_0000);
    adv();
    idle_masters(); wd[1] = 32'hCAFE_F00D;
    eval("wr2");
    chk("wr2.hwdata", bus.hwdata, 32'hCAFE_F00D);
    adv();

    // two-cycle ERROR to M0 while M1 is buffered
    set_req(0, 32'h0000_0500, 2'b10, 1'b0);
    eval("er1"); adv();
    hr = 1'b0; resp_in = 1'b1; idle_masters(); set_req(1, 32'h0000_0600, 2'b10, 1'b0);
    eval("er2");
    chk("er2.m0_hresp", m0.hresp, 1'b1);
    chk("er2.m1_hresp", m1.hresp, 1'b0);
    adv();
    hr = 1'b1; idle_masters();
    eval("er3");
    chk("er3.m0_hresp", m0.hresp, 1'b1);
    chk("er3.m1_hresp", m1.hresp, 1'b0);
    chk("er3.haddr_m1", bus.haddr, 32'h0000_0600);
    chk("er3.hmaster", HMASTER, 1'b1);
    adv();
    resp_in = 1'b0;
    eval("er4"); adv();

    // asynchronous reset while M1 is buffered
    set_req(0, 32'h0000_0700, 2'b10, 1'b0);
    set_req(1, 32'h0000_0800, 2'b10, 1'b0);
    eval("rs1"); adv();
    resp_in = 1'b1;
    drive(); #1;
    chk("rs1.m1_pend", m1.hready, 1'b0);
    chk("rs1.haddr_live", bus.haddr, 32'h0000_0800);
    HRESETn = 1'b0;
    #1;
    chk("rs2.m1_hready", m1.hready, 1'b1);
    chk("rs2.m0_hready", m0.hready, 1'b1);
    chk("rs2.htrans", bus.htrans, 2'b00);
    chk("rs2.haddr", bus.haddr, 32'h0);
    chk("rs2.hmaster", HMASTER, 1'b0);
    chk("rs2.m0_hresp", m0.hresp, 1'b0);
    model_reset();
    idle_masters(); resp_in = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    eval("rs3");
    chk("rs3.htrans", bus.htrans, 2'b00);
    adv();

    // random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        inp[i].addr  = $urandom;
        inp[i].trans = 2'($urandom_range(0, 3));
        inp[i].size  = 3'($urandom_range(0, 7));
        inp[i].write = 1'($urandom_range(0, 1));
        wd[i]        = $urandom;
      end
      hr      = ($urandom_range(0, 3) != 0);
      resp_in = 1'($urandom_range(0, 1));
      rd_in   = $urandom;
      eval("rnd");
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
